// File: rtl/pixel_capture_fifo.sv
`default_nettype none
// ============================================================================
// pixel_capture_fifo : samples ADC words per row strobe, tags row/first, FIFO to store
// Rev 1.0
// ============================================================================
module pixel_capture_fifo #(
    parameter int PIX_W  = 4,
    parameter int DEPTH  = 8,
    parameter int EXPECT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     nre_1,
    input  logic                     nre_2,
    input  logic                     adc,
    input  logic                     erase,
    input  logic [PIX_W-1:0]         adc_data,
    output logic [PIX_W-1:0]         pix_data,
    output logic                     pix_row,
    output logic                     pix_first,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     frame_done,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int WORD_W = PIX_W + 2;
    localparam int NS_W   = $clog2(EXPECT) + 2;

    localparam logic [NS_W-1:0]  NS_MAX    = '1;
    localparam logic [NS_W-1:0]  NS_EXPECT = NS_W'(EXPECT);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_CAP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_adc_q;
    logic              r_erase_q;
    logic              r_first_pend;
    logic [NS_W-1:0]   r_nsamp;

    logic              w_adc_rise;
    logic              w_erase_fall;
    logic              w_erase_rise;
    logic              w_sel_ok;
    logic              w_row;
    logic              w_strobe;
    logic              w_push_req;

    assign w_adc_rise   = adc & ~r_adc_q;
    assign w_erase_fall = ~erase & r_erase_q;
    assign w_erase_rise = erase & ~r_erase_q;
    assign w_strobe     = (r_state == ST_CAP) & w_adc_rise;
    // Exactly one active-low select must be asserted; nre_1 high means row 2.
    assign w_sel_ok     = nre_1 ^ nre_2;
    assign w_row        = nre_1;
    assign w_push_req   = w_strobe & w_sel_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_WAIT;
            r_adc_q      <= 1'b0;
            r_erase_q    <= 1'b1;
            r_first_pend <= 1'b0;
            r_nsamp      <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_adc_q    <= adc;
            r_erase_q  <= erase;
            frame_done <= 1'b0;
            case (r_state)
                ST_WAIT: begin
                    if (w_erase_fall) begin
                        r_state      <= ST_CAP;
                        r_nsamp      <= '0;
                        r_first_pend <= 1'b1;
                    end
                end
                ST_CAP: begin
                    if (w_strobe) begin
                        if (w_sel_ok) begin
                            r_first_pend <= 1'b0;
                            if (r_nsamp != NS_MAX) begin
                                r_nsamp <= r_nsamp + 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    if (w_erase_rise) begin
                        r_state    <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_nsamp != NS_EXPECT) begin
                        frame_err <= 1'b1;
                    end
                    r_state <= ST_WAIT;
                end
                default: begin
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  w_count;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == PTR_DEPTH);
    assign pix_valid = (w_count != '0);
    assign w_pop     = pix_valid & pix_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push    = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= {r_first_pend, w_row, adc_data};
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_req & ~w_push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign {pix_first, pix_row, pix_data} = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_capture_fifo.sv
`default_nettype none
// ============================================================================
// tb_pixel_capture_fifo : randomized + directed bench with a queue-based reference model
// Rev 1.0
// ============================================================================
module tb_pixel_capture_fifo;

    localparam int PIX_W  = 4;
    localparam int DEPTH  = 8;
    localparam int EXPECT = 2;
    localparam int NS_MAX = (1 << ($clog2(EXPECT) + 2)) - 1;

    logic                   clk;
    logic                   reset;
    logic                   nre_1;
    logic                   nre_2;
    logic                   adc;
    logic                   erase;
    logic [PIX_W-1:0]       adc_data;
    logic [PIX_W-1:0]       pix_data;
    logic                   pix_row;
    logic                   pix_first;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   frame_done;
    logic                   frame_err;
    logic                   overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    pixel_capture_fifo #(
        .PIX_W  (PIX_W),
        .DEPTH  (DEPTH),
        .EXPECT (EXPECT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .nre_1      (nre_1),
        .nre_2      (nre_2),
        .adc        (adc),
        .erase      (erase),
        .adc_data   (adc_data),
        .pix_data   (pix_data),
        .pix_row    (pix_row),
        .pix_first  (pix_first),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frame phase, sample bookkeeping and the FIFO as a queue.
    int         m_mode;   // 0 idle, 1 capturing, 2 end-of-frame
    bit         m_adc_q;
    bit         m_erase_q;
    int         m_nsamp;
    bit         m_first;
    logic [5:0] m_q [$];
    bit         m_ovf;
    bit         m_ferr;
    bit         m_fdone;

    logic [5:0] log_q [$];
    int         fd_seen;
    bit         rand_rdy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_adc_q   = 1'b0;
        m_erase_q = 1'b1;
        m_nsamp   = 0;
        m_first   = 1'b0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_ferr    = 1'b0;
        m_fdone   = 1'b0;
    endtask

    // Called at a falling edge; leaves the bench at the following falling edge.
    task automatic do_reset();
        reset = 1'b1;
        nre_1 = 1'b1; nre_2 = 1'b1; adc = 1'b0; erase = 1'b1; adc_data = '0;
        model_reset();
        #1;
        check_val("rst_valid", pix_valid, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_fdone", frame_done, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_ferr", frame_err, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cyc(input logic n1, input logic n2, input logic a, input logic e,
                       input logic [3:0] d);
        logic [5:0] w;
        bit ar, ef, er, pop, full, push, fd;
        nre_1 = n1; nre_2 = n2; adc = a; erase = e; adc_data = d;
        if (rand_rdy) pix_ready = 1'($urandom_range(0, 1));
        #1;
        check_val("valid", pix_valid, (m_q.size() != 0));
        check_val("count", fifo_count, m_q.size());
        check_val("overflow", overflow, m_ovf);
        check_val("frame_err", frame_err, m_ferr);
        check_val("frame_done", frame_done, m_fdone);
        if (m_q.size() != 0) check_val("head_word", {pix_first, pix_row, pix_data}, m_q[0]);
        if (pix_valid && pix_ready) log_q.push_back({pix_first, pix_row, pix_data});
        if (frame_done) fd_seen++;

        ar   = a && !m_adc_q;
        ef   = !e && m_erase_q;
        er   = e && !m_erase_q;
        pop  = pix_ready && (m_q.size() != 0);
        full = (m_q.size() == DEPTH);
        push = 1'b0;
        fd   = 1'b0;
        w    = '0;
        case (m_mode)
            0: if (ef) begin m_mode = 1; m_nsamp = 0; m_first = 1'b1; end
            1: begin
                if (ar) begin
                    if (n1 != n2) begin
                        push = 1'b1;
                        w = {m_first, n1, d};
                        m_first = 1'b0;
                        if (m_nsamp < NS_MAX) m_nsamp++;
                    end else begin
                        m_ferr = 1'b1;
                    end
                end
                if (er) begin m_mode = 2; fd = 1'b1; end
            end
            default: begin
                if (m_nsamp != EXPECT) m_ferr = 1'b1;
                m_mode = 0;
            end
        endcase
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!full || pop) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
        m_fdone   = fd;
        m_adc_q   = a;
        m_erase_q = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom));
    endtask

    task automatic frame_begin();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
    endtask

    task automatic frame_end();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom));
    endtask

    // sel: 0 row 1, 1 row 2, 2 both selects low, 3 both high
    task automatic strobe(input int sel, input logic [3:0] d, input int hold);
        logic n1, n2;
        n1 = (sel == 1) || (sel == 3);
        n2 = (sel == 0) || (sel == 3);
        cyc(n1, n2, 1'b0, 1'b0, 4'($urandom));
        cyc(n1, n2, 1'b1, 1'b0, d);
        for (int i = 1; i < hold; i++) cyc(n1, n2, 1'b1, 1'b0, d + 4'(i));
        cyc(n1, n2, 1'b0, 1'b0, 4'($urandom));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rand_rdy  = 1'b0;
        pix_ready = 1'b0;
        fd_seen   = 0;
        @(negedge clk);
        do_reset();

        // Nominal two-row frame with the consumer always ready
        pix_ready = 1'b1;
        log_q.delete();
        fd_seen = 0;
        idle(2);
        frame_begin();
        strobe(0, 4'hA, 1);
        strobe(1, 4'h5, 1);
        frame_end();
        idle(2);
        check_val("nom_npop", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_val("nom_w0", log_q[0], 6'b1_0_1010);
            check_val("nom_w1", log_q[1], 6'b0_1_0101);
        end
        check_val("nom_fdone_pulses", fd_seen, 1);
        check_val("nom_ferr", frame_err, 0);
        check_val("nom_count", fifo_count, 0);

        // Backpressure: 9 valid strobes over 5 frames into an 8-deep FIFO
        do_reset();
        pix_ready = 1'b0;
        for (int f = 0; f < 5; f++) begin
            frame_begin();
            strobe(0, 4'(2 * f), 1);
            if (f < 4) strobe(1, 4'(2 * f + 1), 1);
            frame_end();
        end
        check_val("bp_count", fifo_count, 8);
        check_val("bp_ovf", overflow, 1);
        check_val("bp_ferr", frame_err, 1);
        log_q.delete();
        pix_ready = 1'b1;
        idle(10);
        check_val("bp_npop", log_q.size(), 8);
        if (log_q.size() == 8) begin
            check_val("bp_first", log_q[0], 6'b1_0_0000);
            check_val("bp_last", log_q[7], 6'b0_1_0111);
        end

        // Full FIFO with simultaneous pop and capture
        do_reset();
        pix_ready = 1'b0;
        for (int f = 0; f < 4; f++) begin
            frame_begin();
            strobe(0, 4'(2 * f), 1);
            strobe(1, 4'(2 * f + 1), 1);
            frame_end();
        end
        log_q.delete();
        frame_begin();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        pix_ready = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'hC);
        pix_ready = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check_val("fpp_count", fifo_count, 8);
        check_val("fpp_ovf", overflow, 0);
        frame_end();
        pix_ready = 1'b1;
        idle(10);
        check_val("fpp_npop", log_q.size(), 9);
        if (log_q.size() == 9) check_val("fpp_tail", log_q[8], 6'b1_0_1100);

        // Both selects low: sample dropped and frame flagged
        do_reset();
        log_q.delete();
        frame_begin();
        strobe(2, 4'h3, 1);
        check_val("bad_sel_ferr", frame_err, 1);
        check_val("bad_sel_count", fifo_count, 0);
        frame_end();

        // Frame with a single strobe is flagged at end of frame
        do_reset();
        frame_begin();
        strobe(0, 4'h1, 1);
        check_val("short_ferr_before", frame_err, 0);
        frame_end();
        check_val("short_ferr_after", frame_err, 1);

        // Long ADC pulse: one word carrying first-cycle data
        do_reset();
        pix_ready = 1'b0;
        frame_begin();
        strobe(1, 4'h9, 4);
        check_val("long_count", fifo_count, 1);
        check_val("long_word", {pix_first, pix_row, pix_data}, 6'b1_1_1001);
        strobe(0, 4'h4, 1);
        frame_end();

        // Reset in the middle of a frame
        do_reset();
        pix_ready = 1'b0;
        fd_seen = 0;
        frame_begin();
        strobe(0, 4'h2, 1);
        do_reset();
        check_val("mid_rst_fdone", fd_seen, 0);
        pix_ready = 1'b1;
        log_q.delete();
        frame_begin();
        strobe(1, 4'h6, 1);
        strobe(0, 4'hE, 1);
        frame_end();
        check_val("mid_rst_npop", log_q.size(), 2);
        if (log_q.size() != 0) check_val("mid_rst_w0", log_q[0], 6'b1_1_0110);
        check_val("mid_rst_ferr", frame_err, 0);

        // Randomized frames with random backpressure
        do_reset();
        rand_rdy = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int ns;
            idle($urandom_range(0, 3));
            frame_begin();
            ns = $urandom_range(0, 3);
            for (int s = 0; s < ns; s++) begin
                int r;
                r = $urandom_range(0, 9);
                strobe((r < 8) ? (r & 1) : (r - 6), 4'($urandom), $urandom_range(1, 3));
            end
            frame_end();
        end
        rand_rdy  = 1'b0;
        pix_ready = 1'b1;
        idle(12);
        check_val("final_count", fifo_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
